mips32_mem_arbiter: RTL and testbench
=====================================

# mips32_mem_arbiter

Single-port memory arbiter for the pipelined MIPS32 core. It shares one unified instruction/data memory between the IF-stage fetch requester and the MEM-stage load/store requester. Each granted access becomes one fixed-latency memory transaction, and completion is returned as a one-cycle valid pulse to the owning requester. It sits between the pipeline's fetch/MEM logic and the memory array, and lets the core run against a single-ported memory.

## Interface
- `AW`, default 32: word-address width.
- `DW`, default 32: data width.
- `LAT`, default 2: memory read latency in cycles, ≥1.
- `STARVE_MAX`, default 4: consecutive data grants allowed while a fetch waits.

Ports:
- `clk` in 1: the single clock; everything is sampled on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `halted` in 1: core halted; blocks new fetch grants.
- `if_req` in 1: fetch request.
- `if_addr` in AW: fetch word address.
- `if_gnt` out 1: fetch granted.
- `if_rvalid` out 1: fetch data valid, one-cycle pulse.
- `if_rdata` out DW: fetched instruction.
- `dm_req` in 1: data request.
- `dm_we` in 1: 1 = store, 0 = load.
- `dm_addr` in AW: data word address.
- `dm_wdata` in DW: store data.
- `dm_gnt` out 1: data granted.
- `dm_rvalid` out 1: data completion pulse, for loads and stores.
- `dm_rdata` out DW: load data.
- `mem_en` out 1: memory access strobe, one cycle.
- `mem_we` out 1: memory write enable.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: memory read data, valid LAT cycles after the `mem_en` cycle.

## Operation
- FSM has two states:
  - IDLE: arbitrate.
  - BUSY: one transaction outstanding, with latency counter `cnt`.
- In IDLE, the eligible requests are `dm_req` and `if_req & ~halted`.
- Default priority: data wins over fetch.
- Grant outputs:
  - `if_gnt`/`dm_gnt` are combinational from state and requests.
  - At most one is high, only in IDLE, for exactly one cycle per transaction.
- Requester rule: hold req/addr/we/wdata stable until the grant is seen; drop or re-present the request in the cycle after the grant.
- On grant:
  - Latch owner, address, we and wdata.
  - Go to BUSY with `cnt` = LAT.
- Memory strobe: `mem_en` is 1 in the first BUSY cycle only. `mem_we`, `mem_addr` and `mem_wdata` are registered and held for the whole of BUSY.
- Latency count: `cnt` decrements each BUSY cycle after the `mem_en` cycle. When `cnt` reaches 0, capture `mem_rdata` into the owner's rdata register (loads and fetches only) and pulse the owner's rvalid in the next cycle.
- Return to IDLE: the FSM is back in IDLE in the cycle rvalid pulses, so a new grant may coincide with that rvalid.
- Stores: `dm_rvalid` still pulses as completion. `dm_rdata` is unchanged.
- `if_rdata` and `dm_rdata` hold their last value until the next capture for that port.
- `halted`:
  - Masks `if_req` at arbitration only.
  - An in-flight fetch still completes.
  - Data accesses are unaffected.
- Reset (async): every output and internal register goes to 0, including all grants, rvalids, rdata, `mem_*`, state = IDLE, `cnt` = 0 and the starvation counter.
- Reset mid-BUSY:
  - The transaction is abandoned.
  - `mem_en`/`mem_we` drop immediately.
  - No rvalid follows reset release.

## Timing
- Grant in cycle T → `mem_en` in T+1 → `mem_rdata` sampled at the end of T+1+LAT → rvalid in T+LAT+2.
- Best-case throughput: one access per LAT+2 cycles.
- Simultaneous requests in IDLE: data is granted in T. The fetch is granted in T+LAT+2 if it is still asserted and no data request is pending, or if starvation forces it.
- A request arriving while BUSY waits until IDLE. There is no queueing beyond the held request.

## Configuration
- `MIPS32_ARB_STARVE_EN` defined:
  - A starvation counter increments on each data grant made while `if_req & ~halted` is pending.
  - When the counter equals STARVE_MAX, the next arbitration with a fetch pending grants the fetch.
  - The counter clears on any fetch grant, and on any arbitration where no fetch is pending.
- `MIPS32_ARB_STARVE_EN` undefined:
  - Strict data priority; STARVE_MAX is ignored and no counter is built.
  - A fetch can wait indefinitely while `dm_req` stays high.

## Test plan
- Single fetch: LAT=2, memory word 5 = 32'h28020001, `if_req` at `if_addr`=5 in cycle 0 → `if_gnt`@0, `mem_en`@1 with `mem_addr`=5 and `mem_we`=0, `if_rvalid`@4 with `if_rdata`=32'h28020001.
- Collision: `if_req` (addr 3) and `dm_req` (load addr 200, mem[200]=7) both in cycle 0, LAT=2 → `dm_gnt`@0, `dm_rvalid`@4 with `dm_rdata`=7, `if_gnt`@4.
- Store then load: store `dm_addr`=198, `dm_wdata`=5040 → `mem_we`=1 with `mem_wdata`=5040 during BUSY, completion `dm_rvalid` with `dm_rdata` unchanged. A following load of 198 → `dm_rdata`=5040.
- Starvation, macro defined, STARVE_MAX=4: `dm_req` and `if_req` held high → exactly 4 `dm_gnt`, then `if_gnt` at the 5th arbitration. Macro undefined → no `if_gnt` while `dm_req` stays high.
- Halt:
  - `halted`=1 with `if_req` and `dm_req` high → only data grants occur.
  - Deassert `halted` with `dm_req` low → `if_gnt` in the next IDLE cycle.
  - A fetch already BUSY when `halted` rises still returns `if_rvalid`.
- Reset mid-access: `rst_n` low in the cycle after `dm_gnt` → all outputs 0 immediately, no `dm_rvalid` after release. A new `if_req` after release is granted in its first cycle.

Source files
------------

// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter: IF fetch and MEM load/store share one fixed-latency memory.
// Define MIPS32_ARB_STARVE_EN to bound how many data grants may pass a waiting fetch.
module mips32_mem_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned LAT        = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          halted,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned CW = (LAT < 1) ? 1 : $clog2(LAT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          owner_dm;
    logic          arb;
    logic          if_elig;
    logic          starved;

    assign arb     = rst_n && (state == IDLE);
    assign if_elig = if_req && !halted;

`ifdef MIPS32_ARB_STARVE_EN
    localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_cnt;

    assign starved = (starve_cnt == SW'(STARVE_MAX));

    // Counts data grants that overtook a pending fetch; any fetch grant or idle fetch side clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (!if_elig || if_gnt) begin
                starve_cnt <= '0;
            end else if (dm_gnt) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end
`else
    // Strict data priority: the fetch side is never promoted
    assign starved = 1'b0 & (STARVE_MAX == 32'd0);
`endif

    assign if_gnt = arb && if_elig && (!dm_req || starved);
    assign dm_gnt = arb && dm_req && !if_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            owner_dm  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_gnt || dm_gnt) begin
                        state     <= BUSY;
                        cnt       <= CW'(LAT);
                        owner_dm  <= dm_gnt;
                        mem_en    <= 1'b1;
                        mem_we    <= dm_gnt && dm_we;
                        mem_addr  <= dm_gnt ? dm_addr : if_addr;
                        mem_wdata <= dm_gnt ? dm_wdata : '0;
                    end
                end
                BUSY: begin
                    // The strobe cycle does not count; read data is due when cnt runs out
                    if (mem_en) begin
                        mem_en <= 1'b0;
                    end else if (cnt == CW'(1)) begin
                        cnt    <= '0;
                        state  <= IDLE;
                        mem_we <= 1'b0;
                        if (owner_dm) begin
                            dm_rvalid <= 1'b1;
                            if (!mem_we) begin
                                dm_rdata <= mem_rdata;
                            end
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Self-checking bench for mips32_mem_arbiter: vector table plus hand-written corner sequences.
module tb_mips32_mem_arbiter;

    localparam int LAT = 2;

    typedef struct {
        logic        is_dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halted = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    logic load_mem = 1'b0;

    sb_t q_if[$];
    sb_t q_dm[$];
    sb_t e_if;
    sb_t e_dm;
    vec_t vecs [10];

    logic [31:0] mem [0:255];
    logic [31:0] pipe_d [LAT];
    logic        pipe_v [LAT];

    mips32_mem_arbiter #(
        .AW(32), .DW(32), .LAT(LAT), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .halted(halted),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data appears LAT cycles after the strobe cycle, garbage otherwise
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A5A500 | 32'(i);
            mem[5]   <= 32'h28020001;
            mem[200] <= 32'd7;
        end else if (mem_en && mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
        pipe_d[0] <= mem[mem_addr[7:0]];
        pipe_v[0] <= mem_en && !mem_we;
        for (int k = 1; k < LAT; k++) begin
            pipe_d[k] <= pipe_d[k-1];
            pipe_v[k] <= pipe_v[k-1];
        end
    end

    assign mem_rdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : 32'hDEADBEEF;

    task automatic chk_b(input string n, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", n, a, e, cyc);
        end
    endtask

    task automatic chk_w(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    task automatic chk_i(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
        end
    endtask

    task automatic push_if(input logic [31:0] d, input int c);
        sb_t s;
        s.data = d;
        s.cyc  = c;
        q_if.push_back(s);
    endtask

    task automatic push_dm(input logic [31:0] d, input int c);
        sb_t s;
        s.data = d;
        s.cyc  = c;
        q_dm.push_back(s);
    endtask

    // Scoreboard: every completion pulse pops one expectation and checks data and cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (if_rvalid) begin
                if (q_if.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL if_rvalid_unexpected: got pulse expected none (cycle %0d)", cyc);
                end else begin
                    e_if = q_if.pop_front();
                    chk_w("if_rdata", if_rdata, e_if.data);
                    chk_i("if_rvalid_cycle", cyc, e_if.cyc);
                end
            end
            if (dm_rvalid) begin
                if (q_dm.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dm_rvalid_unexpected: got pulse expected none (cycle %0d)", cyc);
                end else begin
                    e_dm = q_dm.pop_front();
                    chk_w("dm_rdata", dm_rdata, e_dm.data);
                    chk_i("dm_rvalid_cycle", cyc, e_dm.cyc);
                end
            end
            chk_b("gnt_onehot", if_gnt & dm_gnt, 1'b0);
        end
    end

    task automatic drain(input string n);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (q_if.size() == 0 && q_dm.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: got pending if=%0d dm=%0d expected none", n, q_if.size(), q_dm.size());
            q_if.delete();
            q_dm.delete();
        end
    endtask

    task automatic chk_zero(input string n);
        chk_b({n, "_if_gnt"}, if_gnt, 1'b0);
        chk_b({n, "_dm_gnt"}, dm_gnt, 1'b0);
        chk_b({n, "_if_rvalid"}, if_rvalid, 1'b0);
        chk_b({n, "_dm_rvalid"}, dm_rvalid, 1'b0);
        chk_b({n, "_mem_en"}, mem_en, 1'b0);
        chk_b({n, "_mem_we"}, mem_we, 1'b0);
        chk_w({n, "_mem_addr"}, mem_addr, 32'h0);
        chk_w({n, "_mem_wdata"}, mem_wdata, 32'h0);
        chk_w({n, "_if_rdata"}, if_rdata, 32'h0);
        chk_w({n, "_dm_rdata"}, dm_rdata, 32'h0);
    endtask

    task automatic do_vec(input vec_t v, input int idx);
        int t0;
        logic got;
        logic other;
        @(posedge clk);
        #1;
        if (v.is_dm) begin
            dm_req   = 1'b1;
            dm_we    = v.we;
            dm_addr  = v.addr;
            dm_wdata = v.wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end
        @(negedge clk);
        got   = v.is_dm ? dm_gnt : if_gnt;
        other = v.is_dm ? if_gnt : dm_gnt;
        chk_b($sformatf("vec%0d_gnt", idx), got, 1'b1);
        chk_b($sformatf("vec%0d_other_gnt", idx), other, 1'b0);
        t0 = cyc;
        if (v.is_dm) push_dm(v.exp_rdata, t0 + LAT + 2);
        else         push_if(v.exp_rdata, t0 + LAT + 2);
        @(posedge clk);
        #1;
        dm_req = 1'b0;
        if_req = 1'b0;
        @(negedge clk);
        chk_b($sformatf("vec%0d_mem_en", idx), mem_en, 1'b1);
        chk_b($sformatf("vec%0d_mem_we", idx), mem_we, v.we);
        chk_w($sformatf("vec%0d_mem_addr", idx), mem_addr, v.addr);
        if (v.we) chk_w($sformatf("vec%0d_mem_wdata", idx), mem_wdata, v.wdata);
        @(negedge clk);
        chk_b($sformatf("vec%0d_mem_en_off", idx), mem_en, 1'b0);
        chk_b($sformatf("vec%0d_mem_we_hold", idx), mem_we, v.we);
        chk_w($sformatf("vec%0d_mem_addr_hold", idx), mem_addr, v.addr);
        drain($sformatf("vec%0d", idx));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int c0;
        int ndg;
        int ng_if;
        int ng_dm;
        int nrv;
        logic got;

        vecs[0] = '{1'b0, 1'b0, 32'd5,   32'd0,         32'h28020001};
        vecs[1] = '{1'b1, 1'b0, 32'd200, 32'd0,         32'd7};
        vecs[2] = '{1'b1, 1'b1, 32'd198, 32'd5040,      32'd7};
        vecs[3] = '{1'b1, 1'b0, 32'd198, 32'd0,         32'd5040};
        vecs[4] = '{1'b0, 1'b0, 32'd198, 32'd0,         32'd5040};
        vecs[5] = '{1'b1, 1'b0, 32'd17,  32'd0,         32'hA5A5A511};
        vecs[6] = '{1'b1, 1'b1, 32'd0,   32'hFFFFFFFF,  32'hA5A5A511};
        vecs[7] = '{1'b0, 1'b0, 32'd0,   32'd0,         32'hFFFFFFFF};
        vecs[8] = '{1'b0, 1'b0, 32'd255, 32'd0,         32'hA5A5A5FF};
        vecs[9] = '{1'b1, 1'b0, 32'd255, 32'd0,         32'hA5A5A5FF};

        // Reset with both requests high: every output must stay at zero
        rst_n    = 1'b0;
        if_req   = 1'b1;
        dm_req   = 1'b1;
        load_mem = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        load_mem = 1'b0;
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1;
        if_req = 1'b0;
        dm_req = 1'b0;
        rst_n  = 1'b1;

        for (int i = 0; i < 10; i++) do_vec(vecs[i], i);

        // Collision: data first, fetch granted in the data rvalid cycle
        @(posedge clk);
        #1;
        if_req  = 1'b1;
        if_addr = 32'd3;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'd200;
        @(negedge clk);
        chk_b("col_dm_gnt", dm_gnt, 1'b1);
        chk_b("col_if_gnt_blocked", if_gnt, 1'b0);
        t0 = cyc;
        push_dm(32'd7, t0 + LAT + 2);
        for (int k = 1; k <= LAT + 2; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) dm_req = 1'b0;
            @(negedge clk);
            chk_b($sformatf("col_if_gnt_k%0d", k), if_gnt, k == LAT + 2);
        end
        push_if(32'hA5A5A503, cyc + LAT + 2);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        drain("col");

        // Starvation: data and fetch held high together
        @(posedge clk);
        #1;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'd10;
        if_req  = 1'b1;
        if_addr = 32'd11;
        ndg = 0;
        got = 1'b0;
        c0  = cyc;
`ifdef MIPS32_ARB_STARVE_EN
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (dm_gnt) begin
                ndg++;
                push_dm(32'hA5A5A50A, cyc + LAT + 2);
            end
            if (if_gnt) begin
                got = 1'b1;
                push_if(32'hA5A5A50B, cyc + LAT + 2);
                break;
            end
            @(posedge clk);
            #1;
        end
        chk_i("starve_dm_gnts", ndg, 4);
        chk_b("starve_if_gnt", got, 1'b1);
        chk_i("starve_if_gnt_cycle", cyc, c0 + 4 * (LAT + 2));
        @(posedge clk);
        #1;
        dm_req = 1'b0;
        if_req = 1'b0;
        drain("starve");
`else
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (dm_gnt) begin
                ndg++;
                push_dm(32'hA5A5A50A, cyc + LAT + 2);
            end
            if (if_gnt) got = 1'b1;
            @(posedge clk);
            #1;
        end
        chk_b("nostarve_if_gnt", got, 1'b0);
        chk_i("nostarve_dm_gnts", ndg, 8);
        dm_req = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (if_gnt) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk_b("nostarve_if_after_drop", got, 1'b1);
        chk_i("nostarve_if_cycle", cyc, c0 + 8 * (LAT + 2));
        if (got) push_if(32'hA5A5A50B, cyc + LAT + 2);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        drain("nostarve");
`endif

        // Halt masks fetch arbitration only
        @(posedge clk);
        #1;
        halted  = 1'b1;
        if_req  = 1'b1;
        if_addr = 32'd20;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'd21;
        ng_if = 0;
        ng_dm = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (if_gnt) ng_if++;
            if (dm_gnt) begin
                ng_dm++;
                push_dm(32'hA5A5A515, cyc + LAT + 2);
            end
            @(posedge clk);
            #1;
        end
        dm_req = 1'b0;
        chk_i("halt_if_gnts", ng_if, 0);
        chk_i("halt_dm_gnts", ng_dm, 5);
        drain("halt_dm");
        @(negedge clk);
        chk_b("halt_idle_masked", if_gnt, 1'b0);
        @(posedge clk);
        #1;
        halted = 1'b0;
        @(negedge clk);
        chk_b("unhalt_if_gnt", if_gnt, 1'b1);
        push_if(32'hA5A5A514, cyc + LAT + 2);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        @(posedge clk);
        #1;
        halted = 1'b1;
        drain("halt_inflight");
        halted = 1'b0;

        // Reset in the cycle after a store grant abandons the access
        @(posedge clk);
        #1;
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'd31;
        dm_wdata = 32'h12345678;
        @(negedge clk);
        chk_b("rstmid_dm_gnt", dm_gnt, 1'b1);
        @(posedge clk);
        #1;
        dm_req = 1'b0;
        dm_we  = 1'b0;
        @(negedge clk);
        chk_b("rstmid_mem_en_pre", mem_en, 1'b1);
        chk_b("rstmid_mem_we_pre", mem_we, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("rstmid");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        nrv = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (dm_rvalid || if_rvalid) nrv++;
        end
        chk_i("rstmid_no_rvalid", nrv, 0);
        @(posedge clk);
        #1;
        if_req  = 1'b1;
        if_addr = 32'd40;
        @(negedge clk);
        chk_b("rstmid_if_gnt_first", if_gnt, 1'b1);
        push_if(32'hA5A5A528, cyc + LAT + 2);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        drain("rstmid_if");

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
